// File: rtl/demux_lane_deser.sv
// demux_lane_deser: reassembles the two 1-to-2 demux lanes into words.
// Optional macro LANE_WORD_CNT_EN adds per-lane accepted-word counters.
module demux_lane_deser #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_valid,
    input  logic              sel,
    input  logic [1:0]        y_in,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [DATA_W-1:0] word_data,
    output logic              word_lane,
`ifdef LANE_WORD_CNT_EN
    output logic [15:0]       word_cnt0,
    output logic [15:0]       word_cnt1,
`endif
    output logic              overflow
);

    localparam int CW = $clog2(DATA_W) + 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    logic [DATA_W-1:0] r_sh0, r_sh1;
    logic [CW-1:0]     r_cnt0, r_cnt1;
    logic [DATA_W-1:0] r_hold0, r_hold1;
    logic              r_full0, r_full1;
    logic              r_ptr;
    logic              r_ov;
    logic              r_vld;
    logic [DATA_W-1:0] r_data;
    logic              r_lane;

    logic              w_bit;
    logic              w_shift0, w_shift1;
    logic              w_done0, w_done1;
    logic [DATA_W-1:0] w_word0, w_word1;
    logic              w_take;
    logic              w_pick0, w_pick1;

    assign w_bit    = y_in[sel];
    assign w_shift0 = bit_valid & ~sel;
    assign w_shift1 = bit_valid & sel;
    assign w_done0  = w_shift0 & (r_cnt0 == LAST);
    assign w_done1  = w_shift1 & (r_cnt1 == LAST);
    // New bits enter at the top so the first bit ends in bit 0.
    assign w_word0  = {w_bit, r_sh0[DATA_W-1:1]};
    assign w_word1  = {w_bit, r_sh1[DATA_W-1:1]};
    // Output slot can load when empty or when its word leaves now.
    assign w_take   = ~r_vld | word_ready;
    assign w_pick0  = w_take & r_full0 & (~r_full1 | ~r_ptr);
    assign w_pick1  = w_take & r_full1 & (~r_full0 | r_ptr);

    // Lane 0 assembly and holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh0   <= '0;
            r_cnt0  <= '0;
            r_hold0 <= '0;
            r_full0 <= 1'b0;
        end else begin
            if (w_shift0) begin
                r_sh0  <= w_word0;
                r_cnt0 <= w_done0 ? '0 : r_cnt0 + CW'(1);
            end
            if (w_done0 && (!r_full0 || w_pick0)) begin
                r_hold0 <= w_word0;
                r_full0 <= 1'b1;
            end else if (w_pick0) begin
                r_full0 <= 1'b0;
            end
        end
    end

    // Lane 1 assembly and holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh1   <= '0;
            r_cnt1  <= '0;
            r_hold1 <= '0;
            r_full1 <= 1'b0;
        end else begin
            if (w_shift1) begin
                r_sh1  <= w_word1;
                r_cnt1 <= w_done1 ? '0 : r_cnt1 + CW'(1);
            end
            if (w_done1 && (!r_full1 || w_pick1)) begin
                r_hold1 <= w_word1;
                r_full1 <= 1'b1;
            end else if (w_pick1) begin
                r_full1 <= 1'b0;
            end
        end
    end

    // Sticky drop flag: a word completed into a busy holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ov <= 1'b0;
        end else if ((w_done0 && r_full0 && !w_pick0) ||
                     (w_done1 && r_full1 && !w_pick1)) begin
            r_ov <= 1'b1;
        end
    end

    // Output slot with round-robin pick; pointer moves past the winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= 1'b0;
            r_data <= '0;
            r_lane <= 1'b0;
            r_ptr  <= 1'b0;
        end else if (w_take) begin
            if (w_pick0) begin
                r_vld  <= 1'b1;
                r_data <= r_hold0;
                r_lane <= 1'b0;
                r_ptr  <= 1'b1;
            end else if (w_pick1) begin
                r_vld  <= 1'b1;
                r_data <= r_hold1;
                r_lane <= 1'b1;
                r_ptr  <= 1'b0;
            end else begin
                r_vld  <= 1'b0;
            end
        end
    end

`ifdef LANE_WORD_CNT_EN
    logic [15:0] r_wcnt0, r_wcnt1;

    // Count accepted words per source lane; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wcnt0 <= '0;
            r_wcnt1 <= '0;
        end else if (r_vld && word_ready) begin
            if (r_lane) r_wcnt1 <= r_wcnt1 + 16'd1;
            else        r_wcnt0 <= r_wcnt0 + 16'd1;
        end
    end

    assign word_cnt0 = r_wcnt0;
    assign word_cnt1 = r_wcnt1;
`endif

    assign word_valid = r_vld;
    assign word_data  = r_data;
    assign word_lane  = r_lane;
    assign overflow   = r_ov;

endmodule

// File: tb/tb_demux_lane_deser.sv
// tb_demux_lane_deser: directed scenario bench for demux_lane_deser.
// Expected words are hand-derived LSB-first assemblies of the sent bits.
module tb_demux_lane_deser;

    logic       clk;
    logic       rst_n;
    logic       bit_valid;
    logic       sel;
    logic [1:0] y_in;
    logic       word_valid;
    logic       word_ready;
    logic [7:0] word_data;
    logic       word_lane;
    logic       overflow;
`ifdef LANE_WORD_CNT_EN
    logic [15:0] word_cnt0;
    logic [15:0] word_cnt1;
`endif

    int errors = 0;
    int checks = 0;

    demux_lane_deser #(.DATA_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_valid  (bit_valid),
        .sel        (sel),
        .y_in       (y_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_data  (word_data),
        .word_lane  (word_lane),
`ifdef LANE_WORD_CNT_EN
        .word_cnt0  (word_cnt0),
        .word_cnt1  (word_cnt1),
`endif
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_bit(input logic lane, input logic b);
        @(negedge clk);
        bit_valid = 1'b1;
        sel = lane;
        y_in[lane] = b;
        y_in[!lane] = 1'($urandom_range(0, 1));
        @(negedge clk);
        bit_valid = 1'b0;
    endtask

    task automatic send_word(input logic lane, input logic [7:0] w);
        for (int i = 0; i < 8; i++) send_bit(lane, w[i]);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", word_valid); end
        checks++; if (word_data !== 8'h00) begin errors++; $display("FAIL rst_data got=%h exp=00", word_data); end
        checks++; if (word_lane !== 1'b0) begin errors++; $display("FAIL rst_lane got=%b exp=0", word_lane); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got=%b exp=0", overflow); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        word_ready = 1'b1;
        send_word(1'b0, 8'h4D);
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL single_early got=%b exp=0", word_valid); end
        @(negedge clk);
        checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", word_valid); end
        checks++; if (word_data !== 8'h4D) begin errors++; $display("FAIL single_data got=%h exp=4d", word_data); end
        checks++; if (word_lane !== 1'b0) begin errors++; $display("FAIL single_lane got=%b exp=0", word_lane); end
        @(negedge clk);
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL single_pulse got=%b exp=0", word_valid); end
    endtask

    task automatic test_interleave;
        logic [7:0] a;
        logic [7:0] b;
        a = 8'h3C;
        b = 8'hA5;
        word_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b0, a[i]);
            send_bit(1'b1, b[i]);
        end
        for (int k = 0; k < 2; k++) begin
            checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL il_hold_valid got=%b exp=1", word_valid); end
            checks++; if (word_data !== 8'h3C) begin errors++; $display("FAIL il_hold_data got=%h exp=3c", word_data); end
            checks++; if (word_lane !== 1'b0) begin errors++; $display("FAIL il_hold_lane got=%b exp=0", word_lane); end
            @(negedge clk);
        end
        word_ready = 1'b1;
        @(negedge clk);
        checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL il_second_valid got=%b exp=1", word_valid); end
        checks++; if (word_data !== 8'hA5) begin errors++; $display("FAIL il_second_data got=%h exp=a5", word_data); end
        checks++; if (word_lane !== 1'b1) begin errors++; $display("FAIL il_second_lane got=%b exp=1", word_lane); end
        @(negedge clk);
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL il_empty got=%b exp=0", word_valid); end
        word_ready = 1'b0;
    endtask

    task automatic test_overflow;
        word_ready = 1'b0;
        send_word(1'b0, 8'h11);
        send_word(1'b0, 8'h22);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b exp=0", overflow); end
        send_word(1'b0, 8'h33);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid got=%b exp=1", word_valid); end
        checks++; if (word_data !== 8'h11) begin errors++; $display("FAIL ovf_first got=%h exp=11", word_data); end
        word_ready = 1'b1;
        @(negedge clk);
        checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL ovf_second_valid got=%b exp=1", word_valid); end
        checks++; if (word_data !== 8'h22) begin errors++; $display("FAIL ovf_second got=%h exp=22", word_data); end
        @(negedge clk);
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got=%b exp=0", word_valid); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        word_ready = 1'b0;
    endtask

    task automatic test_gaps;
        logic [7:0] w;
        int n;
        w = 8'hF0;
        word_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1, w[i]);
            n = $urandom_range(1, 5);
            for (int j = 0; j < n; j++) begin
                @(negedge clk);
                sel = 1'($urandom_range(0, 1));
                y_in = 2'($urandom_range(0, 3));
            end
        end
        @(negedge clk);
        @(negedge clk);
        checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL gap_valid got=%b exp=1", word_valid); end
        checks++; if (word_data !== 8'hF0) begin errors++; $display("FAIL gap_data got=%h exp=f0", word_data); end
        checks++; if (word_lane !== 1'b1) begin errors++; $display("FAIL gap_lane got=%b exp=1", word_lane); end
        word_ready = 1'b1;
        @(negedge clk);
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL gap_drain got=%b exp=0", word_valid); end
        word_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        word_ready = 1'b1;
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b1);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL rm_ovf_before got=%b exp=1", overflow); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rm_ovf_clear got=%b exp=0", overflow); end
        @(negedge clk);
        rst_n = 1'b1;
        send_word(1'b0, 8'h81);
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL rm_early got=%b exp=0", word_valid); end
        @(negedge clk);
        checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL rm_valid got=%b exp=1", word_valid); end
        checks++; if (word_data !== 8'h81) begin errors++; $display("FAIL rm_data got=%h exp=81", word_data); end
        checks++; if (word_lane !== 1'b0) begin errors++; $display("FAIL rm_lane got=%b exp=0", word_lane); end
        @(negedge clk);
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL rm_single got=%b exp=0", word_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rm_ovf got=%b exp=0", overflow); end
    endtask

`ifdef LANE_WORD_CNT_EN
    task automatic test_word_cnt;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        word_ready = 1'b1;
        send_word(1'b0, 8'h01);
        send_word(1'b1, 8'h02);
        send_word(1'b0, 8'h03);
        send_word(1'b1, 8'h04);
        send_word(1'b0, 8'h05);
        repeat (3) @(negedge clk);
        checks++; if (word_cnt0 !== 16'd3) begin errors++; $display("FAIL cnt0 got=%0d exp=3", word_cnt0); end
        checks++; if (word_cnt1 !== 16'd2) begin errors++; $display("FAIL cnt1 got=%0d exp=2", word_cnt1); end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        bit_valid = 1'b0;
        sel = 1'b0;
        y_in = 2'b00;
        word_ready = 1'b0;
        test_reset;
        test_single;
        test_interleave;
        test_overflow;
        test_gaps;
        test_reset_mid;
`ifdef LANE_WORD_CNT_EN
        test_word_cnt;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux_lane_deser.md
Name: demux_lane_deser

Overview:
- Downstream consumer of the 1-to-2 bit demux.
- Takes the two demux output lanes and the select that steered them, and assembles each lane's serial bits into DATA_W-bit words.
- Buffers one completed word per lane and presents completed words on a single valid/ready output port.
- Completed words are interleaved round-robin between lanes; feeds the word-level processing stage.

Parameters:
- DATA_W, 8: bits per assembled word (legal range 2..32).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- bit_valid  input  1  qualifies y_in/sel as a real sample this cycle.
- sel  input  1  lane steered by the demux this cycle (0 = lane 0, 1 = lane 1).
- y_in  input  2  demux outputs; only y_in[sel] is sampled, the other bit is ignored.
- word_valid  output  1  output word available.
- word_ready  input  1  consumer accepts word when word_valid and word_ready are both high.
- word_data  output  DATA_W  assembled word.
- word_lane  output  1  lane the word came from.
- overflow  output  1  sticky flag: a completed word was dropped.

Behaviour:
- Reset (rst_n low, asynchronous):
  - word_valid=0, word_data=0, word_lane=0, overflow=0.
  - Both lane shift registers and bit counters = 0.
  - Both holding-register full flags = 0; round-robin pointer = 0 (lane 0 preferred first).
  - Reset mid-word discards partial words and held words without signalling overflow.
- Per-lane assembly:
  - On a clk edge with bit_valid=1, lane `sel` shifts in y_in[sel] LSB-first: first bit lands in bit 0, last bit in bit DATA_W-1.
  - That lane's counter increments; the other lane is untouched.
  - Counter is $clog2(DATA_W)+1 bits wide and wraps to 0 when the DATA_W-th bit is taken.
  - With bit_valid=0, nothing changes; idle gaps of any length between bits are legal.
- Word completion (edge taking the DATA_W-th bit of a lane):
  - If the lane's holding register is empty, or is being drained to the output on this same edge, the full word loads into it and the full flag is set.
  - Otherwise the new word is dropped, the held word is kept, and overflow is set (sticky until reset).
- Output stage: single registered slot (word_valid/word_data/word_lane). Loads on an edge when the slot is empty, or full and accepted (word_valid & word_ready).
- Arbitration:
  - If both holding registers are full, take the lane indicated by the pointer, then toggle the pointer to the other lane.
  - If exactly one is full, take it and set the pointer to the other lane.
  - The chosen holding register's full flag clears on the same edge.
  - If none is full and the slot is accepted, word_valid drops to 0.
- Stability: while word_valid=1 and word_ready=0, word_data and word_lane hold constant. No combinational path from word_ready to word_valid.
- Latency: DATA_W-th bit at edge N → holding load at edge N → word_valid high after edge N+1.
  - Back-to-back acceptance sustains one word per cycle when holding registers are kept filled.
- Simultaneous events:
  - A lane completion and that lane's holding register moving to the output on the same edge is not overflow.
  - Both lanes can hold words at once; both drain in round-robin order.

Optional Feature:
- Macro LANE_WORD_CNT_EN.
- Defined:
  - Adds outputs word_cnt0 and word_cnt1, each 16 bits.
  - word_cntK increments on every accepted output word (word_valid & word_ready) with word_lane=K.
  - Wraps 0xFFFF→0x0000; reset to 0 by rst_n.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan (DATA_W=8):
- Reset then 8 bits on lane 0 (sel=0, y_in[0] = 1,0,1,1,0,0,1,0), word_ready=1 → word_valid pulses 1 cycle, word_data=0x4D, word_lane=0, two edges after last bit.
- Interleave bits of 0xA5 on lane 1 and 0x3C on lane 0, bit by bit, with word_ready=0 → both held, word_valid=1 stable. Raise word_ready → 0x3C/lane0 then 0xA5/lane1 on consecutive cycles.
- Hold word_ready=0 while lane 0 completes three words 0x11, 0x22, 0x33 → output shows 0x11, holding keeps 0x22, 0x33 dropped, overflow=1. After drain: 0x11, 0x22, then word_valid=0; overflow remains 1.
- Insert random bit_valid=0 gaps (1–5 cycles) and toggle y_in[~sel] randomly during a lane-1 word of 0xF0 → word_data=0xF0, no effect from the unselected lane.
- Assert rst_n low after 5 bits of a lane-0 word, release, then send a full 0x81 → only 0x81 emitted, overflow=0.
- With LANE_WORD_CNT_EN, deliver 3 lane-0 and 2 lane-1 words → word_cnt0=3, word_cnt1=2.
